chan_dump_ctrl: RTL and testbench

Sequences the read-out of one captured channel RAM to the host after a dump command (cmd[15:8] = 8'b10000_ccc).
- Walks all ENTRIES locations in circular order, starting at the capture start address.
- Muxes the selected channel's read data and hands each byte to the UART response path over a send/sent handshake.
- Sits in LA_dig between the command decoder, the five channel RAMs (CH1..CH5) and UART_comm.

---
 rtl/la_pkg.sv | 12 +
 rtl/circ_addr_gen.sv | 40 ++++
 rtl/chan_dump_ctrl.sv | 149 ++++++++++++++
 tb/tb_chan_dump_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser dump path.
package la_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LATCH, S_SEND, S_WAIT_TX, S_NAK, S_FIN, S_CKSUM
  } dump_state_t;

  localparam logic [7:0] NAK_BYTE = 8'hEE;
  localparam logic [4:0] DUMP_OPC = 5'b10000;
  localparam int         NUM_CH   = 5;

endpackage

// File: rtl/circ_addr_gen.sv
// Circular read-address generator: base + count, wrapped at ENTRIES by compare.
module circ_addr_gen #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [LOG2-1:0] start_i,
  input  logic            inc_i,
  output logic [LOG2-1:0] addr_o,
  output logic            last_o
);

  localparam logic [LOG2:0]   ENT  = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  logic [LOG2-1:0] base_q, cnt_q;
  logic [LOG2:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      // an out-of-range start address restarts the walk at 0
      base_q <= ({1'b0, start_i} >= ENT) ? '0 : start_i;
      cnt_q  <= '0;
    end else if (inc_i) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    sum    = {1'b0, base_q} + {1'b0, cnt_q};
    addr_o = (sum >= ENT) ? LOG2'(sum - ENT) : sum[LOG2-1:0];
    last_o = (cnt_q == LAST);
  end

endmodule

// File: rtl/chan_dump_ctrl.sv
// Channel RAM dump sequencer: walks one channel circularly and streams bytes to UART.
// Optional trailing checksum byte enabled by CHAN_DUMP_CKSUM_EN.
module chan_dump_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dump_req,
  input  logic [2:0]      dump_chan,
  input  logic            capt_done,
  input  logic [LOG2-1:0] start_addr,
  input  logic [39:0]     ram_rdata,
  output logic [LOG2-1:0] ram_addr,
  output logic            ram_rd,
  output logic [7:0]      resp_data,
  output logic            send_resp,
  input  logic            resp_sent,
  output logic            dump_busy,
  output logic            dump_done
);

  dump_state_t state_q, state_d;
  logic [2:0]  chan_q;
  logic [7:0]  data_q, byte_sel;
  logic        nak_tx_q;
  logic        load, inc, last;

  circ_addr_gen #(.ENTRIES(ENTRIES), .LOG2(LOG2)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .start_i (start_addr),
    .inc_i   (inc),
    .addr_o  (ram_addr),
    .last_o  (last)
  );

  always_comb begin
    case (chan_q)
      3'd0:    byte_sel = ram_rdata[7:0];
      3'd1:    byte_sel = ram_rdata[15:8];
      3'd2:    byte_sel = ram_rdata[23:16];
      3'd3:    byte_sel = ram_rdata[31:24];
      default: byte_sel = ram_rdata[39:32];
    endcase
  end

`ifdef CHAN_DUMP_CKSUM_EN
  logic [7:0] sum_q;
  logic       ck_q;
`endif

  always_comb begin
    state_d   = state_q;
    ram_rd    = 1'b0;
    send_resp = 1'b0;
    dump_busy = 1'b1;
    dump_done = 1'b0;
    load      = 1'b0;
    inc       = 1'b0;
    case (state_q)
      S_IDLE: begin
        dump_busy = 1'b0;
        if (dump_req) begin
          if (capt_done && dump_chan < 3'(NUM_CH)) begin
            state_d = S_RD;
            load    = 1'b1;
          end else begin
            state_d = S_NAK;
          end
        end
      end
      S_RD: begin
        ram_rd  = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: state_d = S_SEND;
      S_SEND: begin
        send_resp = 1'b1;
        state_d   = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (resp_sent) begin
`ifdef CHAN_DUMP_CKSUM_EN
          if (ck_q)      state_d = S_FIN;
          else if (last) state_d = S_CKSUM;
`else
          if (last)      state_d = S_FIN;
`endif
          else begin
            inc     = 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_NAK: begin
        // strobe once on entry, then only listen for the completion
        send_resp = ~nak_tx_q;
        if (nak_tx_q && resp_sent) state_d = S_FIN;
      end
      S_FIN: begin
        dump_busy = 1'b0;
        dump_done = 1'b1;
        state_d   = S_IDLE;
      end
      S_CKSUM: state_d = S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      chan_q   <= '0;
      data_q   <= '0;
      nak_tx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) chan_q <= dump_chan;
      if (state_q == S_IDLE && state_d == S_NAK) begin
        data_q   <= NAK_BYTE;
        nak_tx_q <= 1'b0;
      end
      if (state_q == S_NAK)   nak_tx_q <= 1'b1;
      if (state_q == S_LATCH) data_q   <= byte_sel;
`ifdef CHAN_DUMP_CKSUM_EN
      if (state_q == S_CKSUM) data_q   <= sum_q;
`endif
    end
  end

`ifdef CHAN_DUMP_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || load) begin
      sum_q <= '0;
      ck_q  <= 1'b0;
    end else begin
      if (state_q == S_LATCH) sum_q <= sum_q + byte_sel;
      if (state_q == S_CKSUM) ck_q  <= 1'b1;
    end
  end
`endif

  assign resp_data = data_q;

endmodule

// File: tb/tb_chan_dump_ctrl.sv
// Randomized bench for chan_dump_ctrl with a byte-stream reference model.
module tb_chan_dump_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
`ifdef CHAN_DUMP_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NB = ENTRIES + CK;

  logic            clk = 1'b0, rst = 1'b1, dump_req = 1'b0, capt_done = 1'b0, resp_sent = 1'b0;
  logic [2:0]      dump_chan = '0;
  logic [LOG2-1:0] start_addr = '0;
  logic [39:0]     ram_rdata = '0;
  logic [LOG2-1:0] ram_addr;
  logic            ram_rd, send_resp, dump_busy, dump_done;
  logic [7:0]      resp_data;

  always #5 clk = ~clk;

  chan_dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .dump_req(dump_req), .dump_chan(dump_chan),
    .capt_done(capt_done), .start_addr(start_addr), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .resp_data(resp_data),
    .send_resp(send_resp), .resp_sent(resp_sent), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  logic [7:0] mem [5][ENTRIES];

  always @(posedge clk)
    if (ram_rd && ram_addr < ENTRIES)
      ram_rdata <= {mem[4][ram_addr], mem[3][ram_addr], mem[2][ram_addr],
                    mem[1][ram_addr], mem[0][ram_addr]};

  int checks = 0, errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // UART stand-in: acknowledge each strobe rsp_dly cycles later
  int rsp_dly = 10;
  int rsp_d;
  initial forever begin
    @(negedge clk);
    if (send_resp) begin
      rsp_d = rsp_dly;
      repeat (rsp_d) @(posedge clk);
      #1 resp_sent = 1'b1;
      @(posedge clk);
      #1 resp_sent = 1'b0;
    end
  end

  // Reference model: the whole expected byte stream is built at acceptance
  bit         m_busy = 0, m_done = 0, m_nak = 0, m_pend = 0, was_done;
  int         m_base = 0, m_rdk = 0, done_cnt = 0;
  logic [7:0] exp_q[$], rx_q[$];
  logic [7:0] m_sum;
  logic [LOG2-1:0] pend_addr;

  always @(negedge clk) begin
    chk("busy", dump_busy, m_busy);
    chk("done", dump_done, m_done);
    if (dump_done) done_cnt++;
    if (m_pend && !send_resp) chk("addr_hold", ram_addr, pend_addr);
    if (ram_rd) begin
      if (m_nak || !m_busy) begin
        checks++; errors++;
        $display("FAIL ram_rd_unexpected actual=1 expected=0");
      end else begin
        chk("ram_addr", ram_addr, (m_base + m_rdk) % ENTRIES);
        m_rdk++;
      end
    end
    if (send_resp) begin
      rx_q.push_back(resp_data);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_byte actual=%0h expected=none", resp_data);
      end else chk("byte", resp_data, exp_q.pop_front());
      m_pend = 1; pend_addr = ram_addr;
    end
    was_done = m_done;
    m_done   = 0;
    if (rst) begin
      m_busy = 0; m_pend = 0; m_nak = 0; exp_q.delete();
    end else if (m_busy && m_pend && resp_sent) begin
      m_pend = 0;
      if (exp_q.size() == 0) begin m_busy = 0; m_done = 1; end
    end else if (!m_busy && !was_done && dump_req) begin
      m_busy = 1; m_rdk = 0; rx_q.delete(); exp_q.delete();
      if (capt_done && dump_chan < 5) begin
        m_nak  = 0;
        m_base = (start_addr >= ENTRIES) ? 0 : int'(start_addr);
        m_sum  = 0;
        for (int k = 0; k < ENTRIES; k++) begin
          exp_q.push_back(mem[dump_chan][(m_base + k) % ENTRIES]);
          m_sum += mem[dump_chan][(m_base + k) % ENTRIES];
        end
        if (CK == 1) exp_q.push_back(m_sum);
      end else begin
        m_nak = 1;
        exp_q.push_back(8'hEE);
      end
    end
  end

  task automatic dump(input int ch, input int sa, input bit capt);
    @(posedge clk); #1;
    dump_chan = 3'(ch); start_addr = LOG2'(sa); capt_done = capt; dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int i  = 0;
    while (done_cnt == d0 && i < budget) begin @(posedge clk); i++; end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
    repeat (5) @(posedge clk);
    chk({name, "_done_cnt"}, done_cnt - d0, 1);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin @(posedge clk); i++; end
    if (rx_q.size() < n) begin
      checks++; errors++;
      $display("FAIL rx_timeout actual=%0d expected=%0d", rx_q.size(), n);
    end
  endtask

  initial begin
    int d0;
    for (int c = 0; c < 5; c++)
      for (int i = 0; i < ENTRIES; i++) mem[c][i] = 8'(i % 256);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", dump_busy, 0); chk("rst_send", send_resp, 0);
    chk("rst_rd", ram_rd, 0);      chk("rst_addr", ram_addr, 0);

    // linear dump from address 0
    rsp_dly = 10;
    dump(0, 0, 1);
    wait_done("t1", NB * 20 + 100);
    chk("t1_count", rx_q.size(), NB);
    chk("t1_b0", rx_q[0], 8'h00);
    chk("t1_b255", rx_q[255], 8'hFF);
    chk("t1_b383", rx_q[383], 8'h7F);
    if (CK == 1) chk("t1_cksum", rx_q[384], 8'h40);

    // wrapped dump from address 100
    rsp_dly = 2;
    dump(2, 100, 1);
    wait_done("t2", NB * 12 + 100);
    chk("t2_b0", rx_q[0], 8'h64);
    chk("t2_b283", rx_q[283], 8'h7F);
    chk("t2_b284", rx_q[284], 8'h00);
    chk("t2_last", rx_q[383], 8'h63);

    // rejected requests
    dump(5, 0, 1);
    wait_done("t3a", 100);
    chk("t3a_count", rx_q.size(), 1);
    chk("t3a_byte", rx_q[0], 8'hEE);
    dump(1, 0, 0);
    wait_done("t3b", 100);
    chk("t3b_count", rx_q.size(), 1);
    chk("t3b_byte", rx_q[0], 8'hEE);

    // slow UART plus an ignored second request mid-dump
    rsp_dly = 1000;
    dump(1, 50, 1);
    wait_rx(2, 3000);
    dump(3, 0, 1);
    wait_rx(3, 3000);
    rsp_dly = 2;
    wait_done("t4", NB * 12 + 3000);
    chk("t4_count", rx_q.size(), NB);
    chk("t4_b0", rx_q[0], 8'd50);

    // reset in the middle of a dump
    rsp_dly = 3;
    dump(0, 0, 1);
    wait_rx(11, 1000);
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", dump_busy, 0); chk("t5_send", send_resp, 0); chk("t5_rd", ram_rd, 0);
    repeat (20) @(posedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    dump(0, 0, 1);
    wait_done("t5", NB * 12 + 100);
    chk("t5_b0", rx_q[0], 8'h00);

    // random contents, channels, start addresses and UART delays
    for (int c = 0; c < 5; c++)
      for (int i = 0; i < ENTRIES; i++) mem[c][i] = 8'($urandom);
    for (int t = 0; t < 4; t++) begin
      rsp_dly = int'($urandom_range(1, 4));
      dump(int'($urandom_range(0, 4)), int'($urandom_range(0, 511)), 1);
      wait_done("rnd", NB * 12 + 100);
      chk("rnd_count", rx_q.size(), NB);
    end
    for (int t = 0; t < 2; t++) begin
      dump(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)), 1'($urandom));
      wait_done("rnd_any", NB * 12 + 100);
    end
    chk("final_idle", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
